// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer around one shared full-adder
// cell; operands are consumed LSB first, one bit per clock.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] a_sh_nxt;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] b_sh_nxt;
   logic [WIDTH-1:0] s_sh;
   logic [WIDTH-1:0] s_sh_nxt;
   logic [WIDTH-1:0] s_shift;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic             carry_nxt;
   logic             cout_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;

   logic             fa_s;
   logic             fa_co;

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // new sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts
   assign s_shift = (s_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_comb begin
      state_nxt = state;
      a_sh_nxt  = a_sh;
      b_sh_nxt  = b_sh;
      s_sh_nxt  = s_sh;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      sum_nxt   = sum;
      cout_nxt  = cout;
      unique case (state)
         IDLE: begin
            if (start) begin
               a_sh_nxt  = a;
               b_sh_nxt  = b;
               s_sh_nxt  = '0;
               carry_nxt = cin;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            a_sh_nxt  = a_sh >> 1;
            b_sh_nxt  = b_sh >> 1;
            s_sh_nxt  = s_shift;
            carry_nxt = fa_co;
            cnt_nxt   = cnt + ONE;
            if (cnt == LAST) begin
               sum_nxt   = s_shift;
               cout_nxt  = fa_co;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         state <= state_nxt;
         a_sh  <= a_sh_nxt;
         b_sh  <= b_sh_nxt;
         s_sh  <= s_sh_nxt;
         carry <= carry_nxt;
         cnt   <= cnt_nxt;
         sum   <= sum_nxt;
         cout  <= cout_nxt;
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH 8, 1
// and 13; expected sums are queued at start and popped on done.

module tb_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] av;
   logic [31:0] bv;
   logic        cv;
   logic [2:0]  st;
   logic [2:0]  bz;
   logic [2:0]  dn;
   logic [7:0]  sum8;
   logic [0:0]  sum1;
   logic [12:0] sum13;
   logic        co8;
   logic        co1;
   logic        co13;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done [3] = '{0, 0, 0};

   logic [32:0] q0[$];
   logic [32:0] q1[$];
   logic [32:0] q2[$];

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(st[0]),
      .a(av[7:0]), .b(bv[7:0]), .cin(cv),
      .busy(bz[0]), .done(dn[0]), .sum(sum8), .cout(co8)
   );

   serial_add_ctrl #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .start(st[1]),
      .a(av[0:0]), .b(bv[0:0]), .cin(cv),
      .busy(bz[1]), .done(dn[1]), .sum(sum1), .cout(co1)
   );

   serial_add_ctrl #(.WIDTH(13)) u13 (
      .clk(clk), .rst(rst), .start(st[2]),
      .a(av[12:0]), .b(bv[12:0]), .cin(cv),
      .busy(bz[2]), .done(dn[2]), .sum(sum13), .cout(co13)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic int wid(input int u);
      case (u)
         0:       return 8;
         1:       return 1;
         default: return 13;
      endcase
   endfunction

   function automatic logic [32:0] get_res(input int u);
      case (u)
         0:       return 33'({co8, sum8});
         1:       return 33'({co1, sum1});
         default: return 33'({co13, sum13});
      endcase
   endfunction

   function automatic logic [32:0] ref_add(input int u, input logic [31:0] x,
                                           input logic [31:0] y, input logic c);
      logic [32:0] m;
      m = (33'd1 << wid(u)) - 33'd1;
      return (33'(x) & m) + (33'(y) & m) + 33'(c);
   endfunction

   task automatic sb_push(input int u, input logic [32:0] e);
      case (u)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic sb_pop(input int u, output bit ok, output logic [32:0] e);
      ok = 1'b0;
      e  = '0;
      case (u)
         0:       if (q0.size() > 0) begin ok = 1'b1; e = q0.pop_front(); end
         1:       if (q1.size() > 0) begin ok = 1'b1; e = q1.pop_front(); end
         default: if (q2.size() > 0) begin ok = 1'b1; e = q2.pop_front(); end
      endcase
   endtask

   // result monitor: every done pulse must match the oldest queued sum
   always @(negedge clk) begin
      for (int u = 0; u < 3; u++) begin
         if (dn[u] === 1'b1) begin
            bit          ok;
            logic [32:0] e;
            n_done[u]++;
            sb_pop(u, ok, e);
            if (!ok) chk("spurious_done", 64'(u), 64'hff);
            else     chk("sb_result", get_res(u), e);
         end
      end
   end

   task automatic add(input int u, input logic [31:0] x, input logic [31:0] y,
                      input logic c, input bit noise);
      logic [32:0] e;
      int          nb;
      int          nc;
      e = ref_add(u, x, y, c);
      @(negedge clk);
      av = x;
      bv = y;
      cv = c;
      st[u] = 1'b1;
      sb_push(u, e);
      @(negedge clk);
      st[u] = 1'b0;
      nb = 0;
      nc = 0;
      while (dn[u] !== 1'b1 && nc < 40) begin
         nb += int'(bz[u]);
         nc++;
         if (noise) begin
            av = $urandom;
            bv = $urandom;
            cv = 1'($urandom);
            st[u] = 1'($urandom);
         end
         @(negedge clk);
      end
      st[u] = noise;
      chk("done_seen", 64'(dn[u]), 64'd1);
      chk("busy_len", 64'(nb), 64'(wid(u)));
      chk("latency", 64'(nc), 64'(wid(u)));
      @(negedge clk);
      st[u] = 1'b0;
      chk("done_pulse", 64'(dn[u]), 64'd0);
      chk("hold", get_res(u), e);
      if (noise) begin
         @(negedge clk);
         chk("no_queue", 64'(bz[u]), 64'd0);
      end
   endtask

   initial begin
      int          k;
      int          nd;
      int          last;
      int          dsnap;
      logic [32:0] e;

      rst = 1'b1;
      st  = '0;
      av  = '0;
      bv  = '0;
      cv  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 3; u++) begin
         chk("rst_busy", 64'(bz[u]), 64'd0);
         chk("rst_done", 64'(dn[u]), 64'd0);
         chk("rst_res", get_res(u), 64'd0);
      end

      add(0, 32'h12, 32'h34, 1'b0, 1'b0);
      chk("k_12_34", get_res(0), 64'h046);
      add(0, 32'hff, 32'h01, 1'b0, 1'b0);
      chk("k_ff_01", get_res(0), 64'h100);
      add(0, 32'h5a, 32'ha5, 1'b1, 1'b0);
      chk("k_5a_a5", get_res(0), 64'h100);

      add(0, 32'h3c, 32'h71, 1'b1, 1'b1);
      chk("k_noise", get_res(0), 64'h0ae);

      // abort: reset during the 4th RUN cycle
      @(negedge clk);
      av = 32'h77;
      bv = 32'h11;
      cv = 1'b0;
      st[0] = 1'b1;
      sb_push(0, ref_add(0, 32'h77, 32'h11, 1'b0));
      @(negedge clk);
      st[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_pre_busy", 64'(bz[0]), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 64'(bz[0]), 64'd0);
      chk("abort_done", 64'(dn[0]), 64'd0);
      chk("abort_res", get_res(0), 64'd0);
      q0.delete();
      dsnap = n_done[0];
      repeat (15) @(negedge clk);
      chk("abort_quiet", 64'(n_done[0] - dsnap), 64'd0);
      add(0, 32'h80, 32'h80, 1'b1, 1'b0);

      // start held high: one add every WIDTH+2 cycles
      e = ref_add(0, 32'h21, 32'h43, 1'b1);
      @(negedge clk);
      av = 32'h21;
      bv = 32'h43;
      cv = 1'b1;
      st[0] = 1'b1;
      repeat (3) sb_push(0, e);
      k = 0;
      nd = 0;
      last = 0;
      while (nd < 3 && k < 60) begin
         @(negedge clk);
         k++;
         if (dn[0] === 1'b1) begin
            if (nd == 0) chk("held_first", 64'(k), 64'd9);
            else         chk("held_gap", 64'(k - last), 64'd10);
            last = k;
            nd++;
            if (nd == 3) st[0] = 1'b0;
         end else if (nd > 0) begin
            chk("held_hold", get_res(0), e);
         end
      end
      chk("held_count", 64'(nd), 64'd3);
      repeat (12) @(negedge clk);
      chk("held_stop", 64'(bz[0]), 64'd0);

      add(1, 32'h1, 32'h1, 1'b1, 1'b0);
      chk("w1_111", get_res(1), 64'h3);
      add(1, 32'h0, 32'h1, 1'b0, 1'b0);
      add(1, 32'h1, 32'h1, 1'b1, 1'b1);

      for (int i = 0; i < 20; i++)
         add(0, $urandom, $urandom, 1'($urandom), 1'b0);
      for (int i = 0; i < 20; i++)
         add(2, $urandom, $urandom, 1'($urandom), 1'($urandom));
      add(2, 32'h1fff, 32'h1fff, 1'b1, 1'b0);
      chk("w13_max", get_res(2), 64'h3fff);

      repeat (5) @(negedge clk);
      chk("sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
